back_substitution: RTL and testbench

- Solves the upper-triangular system U·x = b for x, with dimension K ≤ 16, in signed Q11.13 fixed point (24-bit, 1.0 = 0x002000).
- Sits in the OMP least-squares path. The b-vector streams in from calc_b_vector; U is read from an external BRAM with one-cycle read latency.
- Results x[K-1] down to x[0] stream out as write strobes, followed by a done pulse.

---
 rtl/back_substitution.sv | 166 ++++++++++++++++
 tb/tb_back_substitution.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/back_substitution.sv
// Upper-triangular solver U*x = b in signed Q11.13, rows K-1 down to 0.
// U comes from a one-cycle-latency BRAM; x streams out as write strobes.
module back_substitution #(
    parameter int DW   = 24,
    parameter int FRAC = 13,
    parameter int NMAX = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_bsub,
    input  logic [4:0]      K_final,
    input  logic [3:0]      b_idx_in,
    input  logic [DW-1:0]   b_val_in,
    input  logic            b_we_in,
    output logic [5:0]      u_addr,
    input  logic [4*DW-1:0] u_rdata,
    output logic [3:0]      x_idx,
    output logic [DW-1:0]   x_val,
    output logic            x_we,
    output logic            done_bsub
);

    // state    | meaning
    // IDLE     | accept b writes, wait for start
    // ROW_INIT | acc = b[i] << FRAC, j = i+1
    // RD       | issue U[i][j] read, or move on to the diagonal
    // WAIT     | BRAM latency
    // MAC      | acc -= U[i][j] * x[j]
    // DIAG     | issue U[i][i] read
    // WAIT2    | BRAM latency
    // DLAT     | latch divisor, load divider (d = 0 skips to WRITE)
    // DIV      | restoring divide, one quotient bit per cycle
    // WRITE    | x[i] emitted and stored
    // DONE     | done pulse
    typedef enum logic [3:0] {
        S_IDLE, S_ROW_INIT, S_RD, S_WAIT, S_MAC, S_DIAG,
        S_WAIT2, S_DLAT, S_DIV, S_WRITE, S_DONE
    } state_t;

    localparam int AW = 2*DW + 4;
    localparam logic [AW-1:0] POS_LIM = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic [AW-1:0] NEG_LIM = {{(AW-DW){1'b0}}, 1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] SAT_POS = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SAT_NEG = {1'b1, {(DW-1){1'b0}}};

    state_t state, next_state;

    logic [4:0]             k_lat, j, k_eff;
    logic [3:0]             i;
    logic signed [AW-1:0]   acc;
    logic [AW-1:0]          quo;
    logic [DW-1:0]          rem, dvs, q_sat, x_next;
    logic [DW:0]            rem_sh;
    logic                   ge, q_neg;
    logic [5:0]             div_cnt;
    logic signed [DW-1:0]   b_mem [NMAX];
    logic signed [DW-1:0]   x_mem [NMAX];
    logic signed [DW-1:0]   lane;
    logic signed [2*DW-1:0] prod;

    assign k_eff  = (K_final > 5'(NMAX)) ? 5'(NMAX) : K_final;
    assign lane   = u_rdata[DW*int'(i[1:0]) +: DW];
    assign prod   = lane * x_mem[j[3:0]];
    assign rem_sh = {rem, quo[AW-1]};
    assign ge     = (rem_sh >= {1'b0, dvs});

    // quo holds |acc/d|; sign is reapplied while clamping to DW bits
    always_comb begin
        q_sat = quo[DW-1:0];
        if (q_neg)
            q_sat = (quo > NEG_LIM) ? SAT_NEG : DW'(-quo);
        else if (quo > POS_LIM)
            q_sat = SAT_POS;
        x_next = (state == S_DIV) ? q_sat : '0;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (start_bsub) next_state = (K_final == 5'd0) ? S_DONE : S_ROW_INIT;
            S_ROW_INIT: next_state = S_RD;
            S_RD:       next_state = (j < k_lat) ? S_WAIT : S_DIAG;
            S_WAIT:     next_state = S_MAC;
            S_MAC:      next_state = S_RD;
            S_DIAG:     next_state = S_WAIT2;
            S_WAIT2:    next_state = S_DLAT;
            S_DLAT:     next_state = (lane == '0) ? S_WRITE : S_DIV;
            S_DIV:      if (div_cnt == 6'd0) next_state = S_WRITE;
            S_WRITE:    next_state = (i == 4'd0) ? S_DONE : S_ROW_INIT;
            S_DONE:     next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            k_lat     <= '0;
            j         <= '0;
            i         <= '0;
            acc       <= '0;
            quo       <= '0;
            rem       <= '0;
            dvs       <= '0;
            q_neg     <= 1'b0;
            div_cnt   <= '0;
            u_addr    <= '0;
            x_idx     <= '0;
            x_val     <= '0;
            x_we      <= 1'b0;
            done_bsub <= 1'b0;
            for (int n = 0; n < NMAX; n++) begin
                b_mem[n] <= '0;
                x_mem[n] <= '0;
            end
        end else begin
            x_we      <= (next_state == S_WRITE);
            done_bsub <= (next_state == S_DONE);
            if (next_state == S_WRITE) begin
                x_idx    <= i;
                x_val    <= x_next;
                x_mem[i] <= x_next;
            end
            case (state)
                S_IDLE: begin
                    if (b_we_in) b_mem[b_idx_in] <= b_val_in;
                    if (start_bsub) begin
                        k_lat <= k_eff;
                        i     <= 4'(k_eff - 5'd1);
                    end
                end
                S_ROW_INIT: begin
                    acc <= {{(AW-DW-FRAC){b_mem[i][DW-1]}}, b_mem[i], {FRAC{1'b0}}};
                    j   <= {1'b0, i} + 5'd1;
                end
                S_RD:   if (j < k_lat) u_addr <= {j[3:0], i[3:2]};
                S_MAC: begin
                    acc <= acc - {{(AW-2*DW){prod[2*DW-1]}}, prod};
                    j   <= j + 5'd1;
                end
                S_DIAG: u_addr <= {i, i[3:2]};
                S_DLAT: begin
                    dvs     <= lane[DW-1] ? DW'(-lane) : DW'(lane);
                    quo     <= acc[AW-1] ? AW'(-acc) : AW'(acc);
                    rem     <= '0;
                    q_neg   <= acc[AW-1] ^ lane[DW-1];
                    div_cnt <= 6'(AW);
                end
                S_DIV: begin
                    if (div_cnt != 6'd0) begin
                        quo     <= {quo[AW-2:0], ge};
                        rem     <= ge ? DW'(rem_sh - {1'b0, dvs}) : DW'(rem_sh);
                        div_cnt <= div_cnt - 6'd1;
                    end
                end
                S_WRITE: if (i != 4'd0) i <= i - 4'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_back_substitution.sv
// Self-checking bench for back_substitution: a plain-arithmetic solver model
// predicts the x stream; a negedge monitor compares every strobe and done pulse.
module tb_back_substitution;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_bsub;
    logic [4:0]  K_final;
    logic [3:0]  b_idx_in;
    logic [23:0] b_val_in;
    logic        b_we_in;
    logic [5:0]  u_addr;
    logic [95:0] u_rdata;
    logic [3:0]  x_idx;
    logic [23:0] x_val;
    logic        x_we;
    logic        done_bsub;

    back_substitution dut (
        .clk(clk), .rst_n(rst_n), .start_bsub(start_bsub), .K_final(K_final),
        .b_idx_in(b_idx_in), .b_val_in(b_val_in), .b_we_in(b_we_in),
        .u_addr(u_addr), .u_rdata(u_rdata), .x_idx(x_idx), .x_val(x_val),
        .x_we(x_we), .done_bsub(done_bsub)
    );

    always #5 clk = ~clk;

    logic [95:0] mem [64];
    always @(posedge clk) u_rdata <= mem[u_addr];

    longint um [16][16];
    longint bv [16];
    longint mx [16];
    longint exp_idx [$];
    longint exp_val [$];
    logic [23:0] cap_val [16];
    bit     exp_done = 1'b0;
    bit     run_has_x = 1'b0;
    int     pass_cnt = 0, total_cnt = 0;
    int     done_cnt = 0, cyc = 0, last_xwe = 0;

    function automatic void check(string nm, longint act, longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    function automatic longint sat(input longint v);
        if (v > 64'sd8388607)  return 64'sd8388607;
        if (v < -64'sd8388608) return -64'sd8388608;
        return v;
    endfunction

    function automatic longint rs(input int mag);
        return longint'($urandom_range(2*mag)) - longint'(mag);
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            if (x_we && done_bsub)
                check("we_done_overlap", longint'(x_we && done_bsub), 0);
            if (x_we) begin
                if (exp_idx.size() == 0) begin
                    check("x_we_pending", longint'(exp_idx.size()), 1);
                end else begin
                    check("x_idx", longint'(x_idx), exp_idx.pop_front());
                    check("x_val", longint'(x_val), exp_val.pop_front());
                end
                cap_val[x_idx] = x_val;
                last_xwe = cyc;
            end
            if (done_bsub) begin
                check("done_expected", longint'(exp_done), 1);
                check("done_pending_x", longint'(exp_idx.size()), 0);
                if (run_has_x) check("done_after_last_x", longint'(cyc - last_xwe), 1);
                exp_done = 1'b0;
                done_cnt++;
            end
        end
    end

    task automatic prepare_and_start(input int k, input bit write_b);
        longint acc;
        logic [95:0] w;
        int addr;
        exp_idx.delete();
        exp_val.delete();
        for (int n = 0; n < 16; n++) begin
            mx[n] = 0;
            cap_val[n] = 24'h0;
        end
        for (int i = k - 1; i >= 0; i--) begin
            acc = bv[i] * 8192;
            for (int jj = i + 1; jj < k; jj++) acc -= um[i][jj] * mx[jj];
            mx[i] = (um[i][i] == 0) ? 0 : sat(acc / um[i][i]);
            exp_idx.push_back(i);
            exp_val.push_back(mx[i] & 64'hFFFFFF);
        end
        for (int a = 0; a < 64; a++) mem[a] = {$urandom, $urandom, $urandom};
        for (int c = 0; c < 16; c++)
            for (int r = 0; r <= c; r++) begin
                addr = c*4 + r/4;
                w = mem[addr];
                w[(r%4)*24 +: 24] = 24'(um[r][c]);
                mem[addr] = w;
            end
        if (write_b) begin
            for (int n = 0; n < 16; n++) begin
                @(negedge clk);
                b_idx_in = 4'(n);
                b_val_in = 24'(bv[n]);
                b_we_in  = 1'b1;
            end
            @(negedge clk);
            b_we_in = 1'b0;
        end
        exp_done  = 1'b1;
        run_has_x = (k > 0);
        @(negedge clk);
        K_final    = 5'(k);
        start_bsub = 1'b1;
        @(negedge clk);
        start_bsub = 1'b0;
    endtask

    task automatic finish_case(input string nm);
        int d0;
        d0 = done_cnt;
        for (int c = 0; c < 3000 && done_cnt == d0; c++) @(negedge clk);
        check({nm, "_done_seen"}, longint'(done_cnt - d0), 1);
        repeat (3) @(negedge clk);
        check({nm, "_all_x_emitted"}, longint'(exp_idx.size()), 0);
        exp_idx.delete();
        exp_val.delete();
        exp_done = 1'b0;
    endtask

    task automatic clear_system();
        for (int r = 0; r < 16; r++) begin
            bv[r] = 0;
            for (int c = 0; c < 16; c++) um[r][c] = 0;
        end
    endtask

    task automatic setup_case1();
        clear_system();
        um[0][0] = 'h4000; um[0][1] = 'h2000; um[1][1] = 'h6000;
        um[0][2] = 'h2000; um[1][2] = 'h4000; um[2][2] = 'h8000;
        bv[0] = 'h12000; bv[1] = 'h20000; bv[2] = 'h10000;
    endtask

    task automatic check_case1(input string nm);
        check({nm, "_x2"}, longint'(cap_val[2]), 'h004000);
        check({nm, "_x1"}, longint'(cap_val[1]), 'h008000);
        check({nm, "_x0"}, longint'(cap_val[0]), 'h003000);
    endtask

    initial begin
        int d0, k;
        rst_n = 1'b1; start_bsub = 1'b0; K_final = '0;
        b_idx_in = '0; b_val_in = '0; b_we_in = 1'b0;
        for (int a = 0; a < 64; a++) mem[a] = '0;
        repeat (3) @(negedge clk);
        check("rst_x_we", longint'(x_we), 0);
        check("rst_done", longint'(done_bsub), 0);
        check("rst_x_val", longint'(x_val), 0);
        check("rst_u_addr", longint'(u_addr), 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        setup_case1();
        prepare_and_start(3, 1'b1);
        check("c1_model_x2", mx[2], 'h4000);
        check("c1_model_x1", mx[1], 'h8000);
        check("c1_model_x0", mx[0], 'h3000);
        finish_case("c1");
        check_case1("c1");

        clear_system();
        um[0][0] = 'h4000; bv[0] = 'h2000;
        prepare_and_start(1, 1'b1);
        check("c2_model_x0", mx[0], 'h1000);
        finish_case("c2");
        check("c2_x0", longint'(cap_val[0]), 'h001000);

        prepare_and_start(0, 1'b1);
        finish_case("c3");

        clear_system();
        um[0][0] = 'h2000; um[0][1] = 'h2000; um[1][1] = 0;
        bv[0] = 'h4000; bv[1] = 'h6000;
        prepare_and_start(2, 1'b1);
        finish_case("c4");
        check("c4_x1", longint'(cap_val[1]), 'h000000);
        check("c4_x0", longint'(cap_val[0]), 'h004000);

        clear_system();
        for (int n = 0; n < 16; n++) begin
            um[n][n] = 'h2000;
            bv[n] = n * 'h2000;
        end
        prepare_and_start(16, 1'b1);
        finish_case("c5");
        check("c5_x15", longint'(cap_val[15]), 'h01E000);
        check("c5_x6", longint'(cap_val[6]), 'h00C000);
        check("c5_x0", longint'(cap_val[0]), 'h000000);

        setup_case1();
        prepare_and_start(3, 1'b1);
        repeat (10) @(negedge clk);
        d0 = done_cnt;
        exp_idx.delete();
        exp_val.delete();
        exp_done = 1'b0;
        rst_n = 1'b1;
        #1;
        check("abort_x_we", longint'(x_we), 0);
        check("abort_done", longint'(done_bsub), 0);
        check("abort_u_addr", longint'(u_addr), 0);
        check("abort_x_val", longint'(x_val), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (30) @(negedge clk);
        check("abort_no_done", longint'(done_cnt - d0), 0);

        setup_case1();
        for (int n = 0; n < 16; n++) bv[n] = 0;
        prepare_and_start(1, 1'b0);
        finish_case("b_cleared");
        check("b_cleared_x0", longint'(cap_val[0]), 0);

        setup_case1();
        prepare_and_start(3, 1'b1);
        finish_case("c6_rerun");
        check_case1("c6_rerun");

        for (int t = 0; t < 8; t++) begin
            clear_system();
            k = (t == 0) ? 16 : int'($urandom_range(16, 1));
            for (int r = 0; r < 16; r++) begin
                bv[r] = rs('h40000);
                for (int c = r + 1; c < 16; c++) um[r][c] = rs('h8000);
                um[r][r] = longint'($urandom_range('h10000, 'h1000));
                if ($urandom_range(1) == 1) um[r][r] = -um[r][r];
                if ($urandom_range(7) == 0) um[r][r] = 0;
            end
            prepare_and_start(k, 1'b1);
            finish_case("rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
